// File: rtl/testdrive_cmd_regs_pkg.sv
// testdrive_cmd_regs_pkg: address map, register bit positions and word type for the command register block.
package testdrive_cmd_regs_pkg;
    typedef logic [31:0] reg_word_t;
    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_STATUS   = 3'd1;
    localparam logic [2:0] A_CMD_PUSH = 3'd2;
    localparam logic [2:0] A_DONE_CNT = 3'd3;
    localparam logic [2:0] A_IRQ_STAT = 3'd4;
    localparam logic [2:0] A_SCRATCH  = 3'd5;
    localparam logic [2:0] A_TS       = 3'd6;
    localparam logic [2:0] A_LAST_TS  = 3'd7;
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FLUSH  = 2;
    localparam int ST_EMPTY    = 16;
    localparam int ST_FULL     = 17;
    localparam int ST_ENABLE   = 18;
    localparam int IRQ_DONE    = 0;
    localparam int IRQ_OVF     = 1;
endpackage

// File: rtl/testdrive_cmd_regs_sync_fifo.sv
// testdrive_sync_fifo: single-clock FIFO with level, full/empty and synchronous flush.
// Push to a full FIFO and pop from an empty one are ignored; flush beats both.
module testdrive_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;
    assign full    = level_q == LW'(DEPTH);
    assign empty   = level_q == '0;
    assign level   = level_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = flush ? '0 : push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = flush ? '0 : pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = flush ? '0 : level_q + LW'(push_ok) - LW'(pop_ok);
        if (push_ok) mem_d[wr_ptr_q] = din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/testdrive_slave_cmd_regs.sv
// testdrive_slave_cmd_regs: register-mapped command queue with done counter and maskable interrupt.
// TESTDRIVE_CMD_REGS_TIMESTAMP_EN adds a cycle counter at address 6 and last-done timestamp at 7.
module testdrive_slave_cmd_regs
    import testdrive_cmd_regs_pkg::*;
#(
    parameter int C_ADDR_BITS  = 10,
    parameter int C_FIFO_DEPTH = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   WE,
    input  logic [C_ADDR_BITS-1:0] WADDR,
    input  logic [31:0]            WDATA,
    input  logic                   RE,
    input  logic [C_ADDR_BITS-1:0] RADDR,
    output logic [31:0]            RDATA,
    output logic                   CMD_VALID,
    input  logic                   CMD_READY,
    output logic [31:0]            CMD_DATA,
    input  logic                   DONE,
    output logic                   IRQ
);
    localparam int LW = $clog2(C_FIFO_DEPTH) + 1;
    logic            enable_q, enable_d, irq_en_q, irq_en_d, irq_q, irq_d;
    logic [1:0]      irq_stat_q, irq_stat_d;
    reg_word_t       done_cnt_q, done_cnt_d, scratch_q, scratch_d, rdata_q, rdata_d;
    reg_word_t       status, rd_val;
    logic            w_hit, r_hit, wr_ctrl, wr_dcnt, wr_istat, wr_scr;
    logic            push, pop, flush, overflow, full, empty;
    logic [LW-1:0]   level;
    logic [2:0]      w_sel, r_sel;
`ifdef TESTDRIVE_CMD_REGS_TIMESTAMP_EN
    reg_word_t       ts_q, ts_d, last_ts_q, last_ts_d;
`endif
    testdrive_sync_fifo #(.DEPTH(C_FIFO_DEPTH), .WIDTH(32)) u_fifo (
        .clk(CLK), .rst(RST), .flush(flush), .push(push), .pop(pop), .din(WDATA),
        .dout(CMD_DATA), .level(level), .full(full), .empty(empty)
    );
    assign CMD_VALID = enable_q & ~empty;
    assign RDATA     = rdata_q;
    assign IRQ       = irq_q;
    always_comb begin
        w_hit     = WE && ((WADDR >> 3) == '0);
        r_hit     = RE && ((RADDR >> 3) == '0);
        w_sel     = WADDR[2:0];
        r_sel     = RADDR[2:0];
        wr_ctrl   = w_hit && w_sel == A_CTRL;
        wr_dcnt   = w_hit && w_sel == A_DONE_CNT;
        wr_istat  = w_hit && w_sel == A_IRQ_STAT;
        wr_scr    = w_hit && w_sel == A_SCRATCH;
        push      = w_hit && w_sel == A_CMD_PUSH;
        flush     = wr_ctrl && WDATA[CTRL_FLUSH];
        overflow  = push && full;
        pop       = CMD_VALID && CMD_READY;
        enable_d  = wr_ctrl ? WDATA[CTRL_ENABLE] : enable_q;
        irq_en_d  = wr_ctrl ? WDATA[CTRL_IRQ_EN] : irq_en_q;
        scratch_d = wr_scr ? WDATA : scratch_q;
        // a clear racing a DONE leaves a count of one, never zero
        done_cnt_d = wr_dcnt ? 32'(DONE) : (DONE && done_cnt_q != '1) ? done_cnt_q + 32'd1 : done_cnt_q;
        irq_stat_d = (irq_stat_q & ~(wr_istat ? WDATA[1:0] : 2'b00)) | {overflow, DONE};
        irq_d      = irq_en_q & |irq_stat_q;
        status            = '0;
        status[8:0]       = 9'(level);
        status[ST_EMPTY]  = empty;
        status[ST_FULL]   = full;
        status[ST_ENABLE] = enable_q;
        case (r_sel)
            A_CTRL:     rd_val = {30'd0, irq_en_q, enable_q};
            A_STATUS:   rd_val = status;
            A_DONE_CNT: rd_val = done_cnt_q;
            A_IRQ_STAT: rd_val = {30'd0, irq_stat_q};
            A_SCRATCH:  rd_val = scratch_q;
`ifdef TESTDRIVE_CMD_REGS_TIMESTAMP_EN
            A_TS:       rd_val = ts_q;
            A_LAST_TS:  rd_val = last_ts_q;
`endif
            default:    rd_val = '0;
        endcase
        rdata_d = RE ? (r_hit ? rd_val : '0) : rdata_q;
    end
`ifdef TESTDRIVE_CMD_REGS_TIMESTAMP_EN
    always_comb begin
        ts_d      = ts_q + 32'd1;
        last_ts_d = DONE ? ts_q : last_ts_q;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            ts_q      <= '0;
            last_ts_q <= '0;
        end else begin
            ts_q      <= ts_d;
            last_ts_q <= last_ts_d;
        end
    end
`endif
    always_ff @(posedge CLK) begin
        if (RST) begin
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
            irq_stat_q <= '0;
            done_cnt_q <= '0;
            scratch_q  <= '0;
            rdata_q    <= '0;
        end else begin
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            irq_stat_q <= irq_stat_d;
            done_cnt_q <= done_cnt_d;
            scratch_q  <= scratch_d;
            rdata_q    <= rdata_d;
        end
    end
endmodule

// File: tb/tb_testdrive_slave_cmd_regs.sv
// tb_testdrive_slave_cmd_regs: table-driven register vectors plus directed queue, irq and done sequences.
module tb_testdrive_slave_cmd_regs;
    logic        CLK = 0, RST = 1, WE = 0, RE = 0, CMD_READY = 0, DONE = 0;
    logic [9:0]  WADDR = 0, RADDR = 0;
    logic [31:0] WDATA = 0, RDATA, CMD_DATA;
    logic        CMD_VALID, IRQ;
    int          n_vec = 0, n_err = 0;
    logic [31:0] t0, t1;

    typedef struct {
        bit          is_wr;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    localparam int NV = 16;
    vec_t vecs [NV];

    testdrive_slave_cmd_regs dut (
        .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .RE(RE), .RADDR(RADDR),
        .RDATA(RDATA), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_DATA(CMD_DATA),
        .DONE(DONE), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        WE = 1; WADDR = a; WDATA = d;
        @(negedge CLK);
        WE = 0;
    endtask

    task automatic rd(input logic [9:0] a);
        RE = 1; RADDR = a;
        @(negedge CLK);
        RE = 0;
    endtask

    task automatic pulse_done();
        DONE = 1;
        @(negedge CLK);
        DONE = 0;
        @(negedge CLK);
    endtask

    initial begin
        vecs[0]  = '{0, 10'd1,   32'h0,        32'h0001_0000};
        vecs[1]  = '{0, 10'd0,   32'h0,        32'h0};
        vecs[2]  = '{1, 10'd5,   32'hDEAD_BEEF, 32'h0};
        vecs[3]  = '{0, 10'd5,   32'h0,        32'hDEAD_BEEF};
        vecs[4]  = '{1, 10'd0,   32'hFFFF_FFFF, 32'h0};
        vecs[5]  = '{0, 10'd0,   32'h0,        32'h3};
        vecs[6]  = '{0, 10'd1,   32'h0,        32'h0005_0000};
        vecs[7]  = '{1, 10'd0,   32'h0,        32'h0};
        vecs[8]  = '{1, 10'h00D, 32'h55,       32'h0};
        vecs[9]  = '{0, 10'd5,   32'h0,        32'hDEAD_BEEF};
        vecs[10] = '{0, 10'd3,   32'h0,        32'h0};
        vecs[11] = '{0, 10'd4,   32'h0,        32'h0};
        vecs[12] = '{0, 10'd2,   32'h0,        32'h0};
        vecs[13] = '{0, 10'd7,   32'h0,        32'h0};
        vecs[14] = '{0, 10'h009, 32'h0,        32'h0};
        vecs[15] = '{0, 10'd1,   32'h0,        32'h0001_0000};

        repeat (3) @(negedge CLK);
        RST = 0;
        check("reset_rdata", RDATA, 0);
        check("reset_valid", 32'(CMD_VALID), 0);
        check("reset_irq", 32'(IRQ), 0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data);
            else begin
                rd(vecs[i].addr);
                check($sformatf("vec%0d_rdata", i), RDATA, vecs[i].exp);
            end
            check($sformatf("vec%0d_irq", i), 32'(IRQ), 0);
            check($sformatf("vec%0d_valid", i), 32'(CMD_VALID), 0);
        end

        wr(0, 1);
        wr(2, 32'hA0);
        check("push_empty_valid", 32'(CMD_VALID), 1);
        check("head_a0", CMD_DATA, 32'hA0);
        wr(2, 32'hA1);
        wr(2, 32'hA2);
        rd(1);
        check("level3", RDATA, 32'h0004_0003);
        CMD_READY = 1;
        check("drain_a0", CMD_DATA, 32'hA0);
        @(negedge CLK);
        check("drain_a1", CMD_DATA, 32'hA1);
        check("drain_a1_v", 32'(CMD_VALID), 1);
        @(negedge CLK);
        check("drain_a2", CMD_DATA, 32'hA2);
        @(negedge CLK);
        check("drained_valid", 32'(CMD_VALID), 0);
        CMD_READY = 0;
        rd(1);
        check("drained_status", RDATA, 32'h0005_0000);

        wr(0, 0);
        for (int i = 0; i < 17; i++) wr(2, 32'h100 + i);
        rd(1);
        check("full_status", RDATA, 32'h0002_0010);
        rd(4);
        check("ovf_stat", RDATA, 32'h2);
        check("ovf_irq_masked", 32'(IRQ), 0);
        wr(0, 2);
        check("irq_lag", 32'(IRQ), 0);
        @(negedge CLK);
        check("irq_set", 32'(IRQ), 1);
        wr(4, 2);
        check("irq_hold", 32'(IRQ), 1);
        @(negedge CLK);
        check("irq_clr", 32'(IRQ), 0);
        wr(0, 4);
        rd(1);
        check("flush_full", RDATA, 32'h0001_0000);

        wr(0, 3);
        repeat (3) pulse_done();
        rd(3);
        check("done_cnt3", RDATA, 3);
        check("done_irq", 32'(IRQ), 1);
        WE = 1; WADDR = 3; WDATA = 0; DONE = 1;
        @(negedge CLK);
        WE = 0; DONE = 0;
        rd(3);
        check("dcnt_clr_race", RDATA, 1);
        WE = 1; WADDR = 4; WDATA = 1; DONE = 1;
        @(negedge CLK);
        WE = 0; DONE = 0;
        rd(4);
        check("w1c_race", RDATA, 1);
        rd(3);
        check("done_cnt2", RDATA, 2);
        wr(4, 1);
        rd(4);
        check("w1c_done", RDATA, 0);
        check("irq_off", 32'(IRQ), 0);
        WE = 1; WADDR = 5; WDATA = 32'h1234; RE = 1; RADDR = 5;
        @(negedge CLK);
        WE = 0; RE = 0;
        check("rw_same", RDATA, 32'hDEAD_BEEF);
        rd(5);
        check("rw_after", RDATA, 32'h1234);

        wr(0, 0);
        for (int i = 0; i < 5; i++) wr(2, 32'hC0 + i);
        rd(1);
        check("level5", RDATA, 32'h0000_0005);
        CMD_READY = 1;
        wr(0, 5);
        check("flush_valid", 32'(CMD_VALID), 0);
        rd(1);
        check("flush_status", RDATA, 32'h0005_0000);
        check("flush_valid2", 32'(CMD_VALID), 0);
        CMD_READY = 0;

        wr(0, 0);
        wr(2, 32'hE0);
        wr(2, 32'hE1);
        RST = 1;
        @(negedge CLK);
        RST = 0;
        check("rst_mid_rdata", RDATA, 0);
        wr(0, 1);
        check("rst_mid_valid", 32'(CMD_VALID), 0);
        rd(1);
        check("rst_mid_status", RDATA, 32'h0005_0000);

`ifdef TESTDRIVE_CMD_REGS_TIMESTAMP_EN
        rd(6);
        t0 = RDATA;
        repeat (9) @(negedge CLK);
        rd(6);
        t1 = RDATA;
        check("ts_delta", t1 - t0, 10);
        DONE = 1; RE = 1; RADDR = 6;
        @(negedge CLK);
        DONE = 0; RE = 0;
        t0 = RDATA;
        rd(7);
        check("last_done_ts", RDATA, t0);
`else
        rd(6);
        check("ts_unmapped", RDATA, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/testdrive_slave_cmd_regs.md
# testdrive_slave_cmd_regs

Register-mapped command block that consumes the write/read strobe stream produced by the virtual slave BFM and turns it into a host-controlled command queue for a downstream core. Host writes land in control registers or push 32-bit command words into an internal FIFO. The core drains that FIFO through a valid/ready handshake and reports completions via a pulse. Completions are counted and raise a maskable interrupt; reads return status with fixed one-cycle latency.

## Interface
- C_ADDR_BITS, 10, word-address width of WADDR/RADDR; only bits [2:0] decoded, upper bits must be zero for a hit
- C_FIFO_DEPTH, 16, command FIFO entries; power of two, 2..256
- CLK  in  1  system clock, single clock domain
- RST  in  1  reset, synchronous, active-high
- WE  in  1  write strobe, one cycle per write
- WADDR  in  C_ADDR_BITS  write word address
- WDATA  in  32  write data
- RE  in  1  read strobe, one cycle per read
- RADDR  in  C_ADDR_BITS  read word address
- RDATA  out  32  read data, registered
- CMD_VALID  out  1  command word available
- CMD_READY  in  1  core accepts command
- CMD_DATA  out  32  head-of-FIFO command word
- DONE  in  1  single-cycle completion pulse from core
- IRQ  out  1  interrupt, level

## Operation
- Address map (word): 0 CTRL RW, 1 STATUS RO, 2 CMD_PUSH WO, 3 DONE_CNT RO/write-clears, 4 IRQ_STAT W1C, 5 SCRATCH RW; unmapped reads return 0, unmapped writes ignored.
- CTRL: bit0 ENABLE, bit1 IRQ_EN, bit2 FLUSH (self-clearing, always reads 0); other bits read 0.
- STATUS: [8:0] FIFO level, bit16 EMPTY, bit17 FULL, bit18 ENABLE.
- CMD_PUSH write: push WDATA if FIFO not full at start of cycle; if full, word dropped and IRQ_STAT bit1 (OVERFLOW) set. A pop in the same cycle does not rescue a push to a full FIFO.
- CMD_VALID = ENABLE & !EMPTY; CMD_DATA = head entry (don't-care when CMD_VALID=0). Pop on CMD_VALID & CMD_READY.
- Push and pop in same cycle on non-empty, non-full FIFO: level unchanged, both succeed. Push to empty FIFO: CMD_VALID rises next cycle.
- FLUSH: pointers and level cleared at the edge of the write; a concurrent push or pop in that cycle is discarded.
- Clearing ENABLE holds queued entries; CMD_VALID drops the next cycle.
- DONE: DONE_CNT += 1, saturating at 0xFFFF_FFFF; sets IRQ_STAT bit0 (DONE_PEND). Write to DONE_CNT clears it; simultaneous DONE makes result 1.
- IRQ_STAT W1C: same-cycle set event wins over clear.
- IRQ = IRQ_EN & (DONE_PEND | OVERFLOW), registered.
- Simultaneous WE and RE to same address: read returns pre-write value.

## Timing
- RE at edge N → RDATA valid after edge N+1, held until next RE.
- Write effects visible to registers/outputs after the write edge; IRQ one further cycle after source bit.
- Reset values: RDATA 0, CMD_VALID 0, IRQ 0, CTRL 0, DONE_CNT 0, IRQ_STAT 0, SCRATCH 0, FIFO empty; CMD_DATA don't-care. Reset mid-transfer discards FIFO contents.

## Configuration
- TESTDRIVE_CMD_REGS_TIMESTAMP_EN defined: 32-bit free-running cycle counter (reset 0, wraps) readable at address 6; DONE also latches it into address 7 (LAST_DONE_TS).
- Undefined: addresses 6 and 7 unmapped (read 0); no counter logic.

## Structure
- Package testdrive_cmd_regs_pkg: address constants, CTRL/STATUS/IRQ_STAT bit positions, register-word typedef.
- Sub-module testdrive_sync_fifo (parameterised depth/width, level, full/empty, flush); register decode and IRQ in top.

## Test plan
- Reset, read addr 1 → RDATA 0x0001_0000 one cycle after RE; IRQ 0, CMD_VALID 0.
- CTRL=1, push 0xA0..0xA2, CMD_READY=1 → CMD_DATA 0xA0,0xA1,0xA2 on consecutive cycles; STATUS level back to 0.
- ENABLE=0, push 17 words (depth 16) → STATUS 0x0002_0010, IRQ_STAT=2; CTRL=2 → IRQ=1; W1C 2 → IRQ=0.
- CTRL=3, three DONE pulses → DONE_CNT 3, IRQ 1; write DONE_CNT with DONE same cycle → reads 1.
- Fill 5 entries, write CTRL=5 while CMD_READY=1 → level 0, no further CMD_VALID.
- With macro: read addr 6 twice, 10 cycles apart → difference 10; DONE at counter value T → addr 7 reads T.
